// File: rtl/mem_access_ctrl.sv
// Load/store initiator for the data-memory port: LOAD, STORE, SWAP and INC over
// valid/ready request/response channels, timed to a negedge-sampling memory.
module mem_access_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [1:0]        i_req_op,
    input  logic [ADDR_W-1:0] i_req_base,
    input  logic [ADDR_W-1:0] i_req_offset,
    input  logic [DATA_W-1:0] i_req_wdata,
    output logic              o_resp_valid,
    input  logic              i_resp_ready,
    output logic [DATA_W-1:0] o_resp_rdata,
    output logic              o_busy,
    output logic [7:0]        o_op_count,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_wr_en,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    // state | meaning
    // IDLE  | waiting for a request, req_ready high
    // RD    | one read cycle at the effective address
    // WR    | one write cycle at the effective address
    // RESP  | response presented until resp_ready is sampled high
    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_SWAP  = 2'b10;
    localparam logic [1:0] OP_INC   = 2'b11;

    state_t            r_state, w_state_nxt;
    logic [1:0]        r_op, w_op_nxt;
    logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
    logic [DATA_W-1:0] r_old, w_old_nxt;
    logic              r_req_ready, w_req_ready_nxt;
    logic              r_resp_valid, w_resp_valid_nxt;
    logic [DATA_W-1:0] r_resp_rdata, w_resp_rdata_nxt;
    logic              r_busy, w_busy_nxt;
    logic [7:0]        r_op_count, w_op_count_nxt;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
    logic              r_mem_wr_en, w_mem_wr_en_nxt;
    logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nxt;
    logic [ADDR_W-1:0] w_ea;
    logic              w_accept;

    assign w_ea     = i_req_base + i_req_offset;
    assign w_accept = (r_state == S_IDLE) && i_req_valid && r_req_ready;

    always_comb begin
        w_state_nxt      = r_state;
        w_op_nxt         = r_op;
        w_wdata_nxt      = r_wdata;
        w_old_nxt        = r_old;
        w_resp_valid_nxt = r_resp_valid;
        w_resp_rdata_nxt = r_resp_rdata;
        w_op_count_nxt   = r_op_count;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_wr_en_nxt  = 1'b0;
        w_mem_wdata_nxt  = r_mem_wdata;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_op_nxt       = i_req_op;
                    w_wdata_nxt    = i_req_wdata;
                    w_mem_addr_nxt = w_ea;
                    if (i_req_op == OP_STORE) begin
                        w_state_nxt     = S_WR;
                        w_mem_wr_en_nxt = 1'b1;
                        w_mem_wdata_nxt = i_req_wdata;
                    end else begin
                        w_state_nxt = S_RD;
                    end
                end
            end
            S_RD: begin
                // Read data arrived at the mid-cycle negedge; old_q is only
                // registered here, so INC adds to the live read data.
                w_old_nxt = i_mem_rdata;
                case (r_op)
                    OP_SWAP: begin
                        w_state_nxt     = S_WR;
                        w_mem_wr_en_nxt = 1'b1;
                        w_mem_wdata_nxt = r_wdata;
                    end
                    OP_INC: begin
                        w_state_nxt     = S_WR;
                        w_mem_wr_en_nxt = 1'b1;
                        w_mem_wdata_nxt = i_mem_rdata + 1'b1;
                    end
                    default: begin
                        w_state_nxt      = S_RESP;
                        w_resp_valid_nxt = 1'b1;
                        w_resp_rdata_nxt = i_mem_rdata;
                    end
                endcase
            end
            S_WR: begin
                w_state_nxt      = S_RESP;
                w_resp_valid_nxt = 1'b1;
                w_resp_rdata_nxt = (r_op == OP_STORE) ? i_mem_rdata : r_old;
            end
            S_RESP: begin
                if (i_resp_ready) begin
                    w_state_nxt      = S_IDLE;
                    w_resp_valid_nxt = 1'b0;
                    w_op_count_nxt   = r_op_count + 8'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        w_req_ready_nxt = (w_state_nxt == S_IDLE);
        w_busy_nxt      = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_op         <= OP_LOAD;
            r_wdata      <= '0;
            r_old        <= '0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_busy       <= 1'b0;
            r_op_count   <= '0;
            r_mem_addr   <= '0;
            r_mem_wr_en  <= 1'b0;
            r_mem_wdata  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_op         <= w_op_nxt;
            r_wdata      <= w_wdata_nxt;
            r_old        <= w_old_nxt;
            r_req_ready  <= w_req_ready_nxt;
            r_resp_valid <= w_resp_valid_nxt;
            r_resp_rdata <= w_resp_rdata_nxt;
            r_busy       <= w_busy_nxt;
            r_op_count   <= w_op_count_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_wr_en  <= w_mem_wr_en_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
        end
    end

    assign o_req_ready  = r_req_ready;
    assign o_resp_valid = r_resp_valid;
    assign o_resp_rdata = r_resp_rdata;
    assign o_busy       = r_busy;
    assign o_op_count   = r_op_count;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_wr_en  = r_mem_wr_en;
    assign o_mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: vector table of single operations against a
// negedge-sampling memory, plus back-pressure and reset-during-write sequences.
module tb_mem_access_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [7:0] req_base, req_offset, req_wdata;
    logic       resp_valid;
    logic       resp_ready;
    logic [7:0] resp_rdata;
    logic       busy;
    logic [7:0] op_count;
    logic [7:0] mem_addr;
    logic       mem_wr_en;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;

    logic [7:0] mem [256];

    int n_vec = 0;
    int n_err = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.ADDR_W(8), .DATA_W(8)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_op     (req_op),
        .i_req_base   (req_base),
        .i_req_offset (req_offset),
        .i_req_wdata  (req_wdata),
        .o_resp_valid (resp_valid),
        .i_resp_ready (resp_ready),
        .o_resp_rdata (resp_rdata),
        .o_busy       (busy),
        .o_op_count   (op_count),
        .o_mem_addr   (mem_addr),
        .o_mem_wr_en  (mem_wr_en),
        .o_mem_wdata  (mem_wdata),
        .i_mem_rdata  (mem_rdata)
    );

    // Data memory: samples and answers on the negedge; a write reads back the new value.
    always @(negedge clk) begin
        if (mem_wr_en) begin
            mem[mem_addr] <= mem_wdata;
            mem_rdata     <= mem_wdata;
        end else begin
            mem_rdata <= mem[mem_addr];
        end
    end

    typedef struct {
        logic [1:0] op;
        logic [7:0] base;
        logic [7:0] off;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
        logic [7:0] exp_addr;
        int         exp_lat;
        int         exp_wr;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Presents one request with resp_ready high; caller is #1 after a posedge in IDLE.
    task automatic do_vec(input vec_t v, input string tag);
        int cyc = 0;
        int wr = 0;
        int stray = 0;
        logic [7:0] addr1;
        check({tag, ".req_ready"}, int'(req_ready), 1);
        req_valid  = 1'b1;
        req_op     = v.op;
        req_base   = v.base;
        req_offset = v.off;
        req_wdata  = v.wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_wdata = 8'hEE;
        cyc   = 1;
        addr1 = mem_addr;
        if (mem_wr_en) wr++;
        if (req_ready || !busy) stray++;
        while (!resp_valid && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
            if (mem_wr_en) wr++;
            if (req_ready || !busy) stray++;
        end
        check({tag, ".latency"}, cyc, v.exp_lat);
        check({tag, ".wr_pulses"}, wr, v.exp_wr);
        check({tag, ".mem_addr"}, int'(addr1), int'(v.exp_addr));
        check({tag, ".rdata"}, int'(resp_rdata), int'(v.exp_rdata));
        check({tag, ".ready_while_busy"}, stray, 0);
        @(posedge clk); #1;
        exp_cnt = (exp_cnt + 1) % 256;
        check({tag, ".resp_valid_drop"}, int'(resp_valid), 0);
        check({tag, ".op_count"}, int'(op_count), exp_cnt);
        check({tag, ".wr_en_idle"}, int'(mem_wr_en), 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".req_ready"}, int'(req_ready), 1);
        check({tag, ".resp_valid"}, int'(resp_valid), 0);
        check({tag, ".resp_rdata"}, int'(resp_rdata), 0);
        check({tag, ".busy"}, int'(busy), 0);
        check({tag, ".op_count"}, int'(op_count), 0);
        check({tag, ".mem_addr"}, int'(mem_addr), 0);
        check({tag, ".mem_wr_en"}, int'(mem_wr_en), 0);
        check({tag, ".mem_wdata"}, int'(mem_wdata), 0);
    endtask

    initial begin
        //            op     base   off    wdata  rdata  addr   lat wr
        vecs[0]  = '{2'b01, 8'h10, 8'h05, 8'hA5, 8'hA5, 8'h15, 2, 1};
        vecs[1]  = '{2'b00, 8'h15, 8'h00, 8'h00, 8'hA5, 8'h15, 2, 0};
        vecs[2]  = '{2'b01, 8'h15, 8'h00, 8'hFF, 8'hFF, 8'h15, 2, 1};
        vecs[3]  = '{2'b11, 8'h15, 8'h00, 8'h42, 8'hFF, 8'h15, 3, 1};
        vecs[4]  = '{2'b00, 8'h15, 8'h00, 8'h00, 8'h00, 8'h15, 2, 0};
        vecs[5]  = '{2'b01, 8'h15, 8'h00, 8'h77, 8'h77, 8'h15, 2, 1};
        vecs[6]  = '{2'b10, 8'hF0, 8'h25, 8'h3C, 8'h77, 8'h15, 3, 1};
        vecs[7]  = '{2'b00, 8'h15, 8'h00, 8'h00, 8'h3C, 8'h15, 2, 0};
        vecs[8]  = '{2'b11, 8'hF0, 8'h20, 8'h99, 8'h00, 8'h10, 3, 1};
        vecs[9]  = '{2'b00, 8'h08, 8'h08, 8'h00, 8'h01, 8'h10, 2, 0};
        vecs[10] = '{2'b10, 8'h80, 8'h80, 8'h5C, 8'h00, 8'h00, 3, 1};

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem_rdata  = 8'h00;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_op     = 2'b00;
        req_base   = 8'h00;
        req_offset = 8'h00;
        req_wdata  = 8'h00;
        resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_values("reset");

        for (int i = 0; i < 11; i++) do_vec(vecs[i], $sformatf("vec%0d", i));

        // Back-pressure on a LOAD of 0x15 (holds 0x3C).
        begin
            int waited = 0;
            int bad = 0;
            resp_ready = 1'b0;
            req_valid  = 1'b1;
            req_op     = 2'b00;
            req_base   = 8'h15;
            req_offset = 8'h00;
            @(posedge clk); #1;
            req_valid = 1'b0;
            while (!resp_valid && waited < 10) begin
                @(posedge clk); #1;
                waited++;
            end
            check("bp.resp_valid_rise", int'(resp_valid), 1);
            for (int c = 0; c < 5; c++) begin
                @(posedge clk); #1;
                if (!resp_valid || resp_rdata != 8'h3C || req_ready || mem_wr_en) bad++;
            end
            check("bp.held_stable", bad, 0);
            check("bp.op_count_held", int'(op_count), exp_cnt);
            resp_ready = 1'b1;
            @(posedge clk); #1;
            exp_cnt = (exp_cnt + 1) % 256;
            check("bp.op_count_release", int'(op_count), exp_cnt);
            check("bp.resp_valid_drop", int'(resp_valid), 0);
        end

        // Reset lands on the closing edge of a STORE's WR cycle.
        begin
            int seen = 0;
            req_valid  = 1'b1;
            req_op     = 2'b01;
            req_base   = 8'h40;
            req_offset = 8'h00;
            req_wdata  = 8'h5A;
            @(posedge clk); #1;
            req_valid = 1'b0;
            check("rstwr.in_wr", int'(mem_wr_en), 1);
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            check_reset_values("rstwr");
            exp_cnt = 0;
            repeat (4) begin
                @(posedge clk); #1;
                if (resp_valid) seen++;
            end
            check("rstwr.no_resp", seen, 0);
            do_vec('{2'b00, 8'h30, 8'h10, 8'h00, 8'h5A, 8'h40, 2, 0}, "rstwr.load");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Load/store initiator for the 8-bit RISC core's data memory; owns the data-memory port (address, write enable, write data) and consumes its read data.
- Accepts one memory operation at a time from the execute stage over a valid/ready request channel and returns results over a valid/ready response channel.
- Supports LOAD, STORE and two read-modify-write ops, SWAP and INC, sequenced by an FSM timed to the memory's negedge sampling.

Parameters:
- ADDR_W, 8, memory address width; address arithmetic wraps mod 2^ADDR_W.
- DATA_W, 8, data width; INC wraps mod 2^DATA_W.

Ports:
- clk  in  1  system clock; all controller state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_op  in  2  00=LOAD, 01=STORE, 10=SWAP, 11=INC.
- req_base  in  ADDR_W  base address.
- req_offset  in  ADDR_W  unsigned offset.
- req_wdata  in  DATA_W  store/swap data; ignored for LOAD and INC.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts response.
- resp_rdata  out  DATA_W  LOAD: value read. SWAP/INC: old value. STORE: value written.
- busy  out  1  FSM not in IDLE.
- op_count  out  8  completed-op counter; wraps at 255 to 0.
- mem_addr  out  ADDR_W  to data memory address.
- mem_wr_en  out  1  to data memory write enable.
- mem_wdata  out  DATA_W  to data memory write data.
- mem_rdata  in  DATA_W  from data memory read data.

Behaviour:
- Memory timing contract: the memory samples mem_addr, mem_wr_en and mem_wdata on the negedge of clk. It updates mem_rdata on the same negedge. On a write cycle mem_rdata returns the newly written value.
- All controller outputs are registered. Memory signals therefore change only on posedge, and are stable at the mid-cycle negedge.
- Reset values: state=IDLE; req_ready=1; resp_valid=0; resp_rdata=0; busy=0; op_count=0; mem_addr=0; mem_wr_en=0; mem_wdata=0.
- Effective address: ea = (req_base + req_offset) mod 2^ADDR_W, latched at accept. Example: 0xF0+0x20 gives 0x10.
- Accept rule: accept happens at a posedge where req_valid && req_ready. req_ready=1 only in IDLE. All req_* fields are latched at accept.
- State IDLE: mem_wr_en=0; mem_addr holds its last value.
  - On accept with STORE: go to WR.
  - On accept with any other op: go to RD.
- State RD, one cycle: mem_addr=ea, mem_wr_en=0. At the closing posedge, capture mem_rdata into old_q.
  - LOAD: resp_rdata=old_q, go to RESP.
  - SWAP: go to WR with mem_wdata=latched wdata.
  - INC: go to WR with mem_wdata=(old_q+1) mod 2^DATA_W.
- State WR, one cycle: mem_addr=ea, mem_wr_en=1. At the closing posedge, mem_wr_en returns to 0 and the FSM goes to RESP.
  - STORE: resp_rdata=mem_rdata, which equals the written data.
  - SWAP and INC: resp_rdata=old_q.
- State RESP: resp_valid=1 and resp_rdata held stable until resp_ready is sampled high. On that posedge: resp_valid returns to 0, op_count increments, FSM returns to IDLE.
- There is no accept in the same cycle as a response handshake; the next accept occurs no earlier than the following posedge.
- Latency, accept edge to resp_valid high: LOAD 2 cycles, STORE 2, SWAP 3, INC 3, with resp_ready tied high.
- Back-pressure: resp_ready=0 holds RESP indefinitely. There are no further memory accesses during this time, and mem_wr_en stays 0.
- mem_wr_en is high for exactly one cycle per STORE/SWAP/INC and never for LOAD.
- Reset mid-operation: rst is sampled at posedge.
  - A WR cycle already in progress has been committed at its negedge. A RD cycle is discarded.
  - Outputs return to reset values, and any pending response is dropped without a count.
  - op_count resets to 0.
- An unknown op cannot occur (2-bit encoding is fully defined).

Test Plan:
- Reset, then STORE base=0x10 off=0x05 wdata=0xA5, resp_ready=1 -> exactly one cycle with mem_wr_en=1 at mem_addr=0x15; resp_valid 2 cycles after accept with rdata=0xA5; op_count=1.
- LOAD 0x15 after the previous step -> no write pulse; resp_rdata=0xA5 at accept+2; req_ready low during RD and RESP.
- INC at 0x15 holding 0xFF -> resp_rdata=0xFF; following LOAD 0x15 returns 0x00 (wrap); mem_wr_en pulses once; latency 3.
- SWAP base=0xF0 off=0x25 wdata=0x3C at a location holding 0x77 -> mem_addr=0x15 (address wrap); resp_rdata=0x77; memory then holds 0x3C.
- resp_ready held low 5 cycles after a LOAD -> resp_valid and resp_rdata stable for all 5 cycles; req_ready=0; no new mem_wr_en; op_count increments once on release.
- rst asserted during the WR cycle of a STORE of 0x5A, then released -> outputs at reset values, op_count=0, no response; a later LOAD of that address returns 0x5A.
